bus_ready_generator: RTL and testbench
======================================

// Module: bus_ready_generator
// PURPOSE
//  Wait-state and READY generator feeding the bus arbiter (8284A RDY path + XT wait-state logic).
//  Watches arbiter command strobes, inserts programmed wait states and stretches them on io_channel_ready.
//  Drives the CPU READY input and the 8237 dma_ready input; gates CPU READY with dma_wait_n.
//  Flags a one-clock bus_timeout when a stretched cycle never completes.
// PARAMETERS
//  IO_WAIT_STATES   1    wait clocks inserted on CPU I/O read/write cycles
//  MEM_WAIT_STATES  0    wait clocks inserted on CPU memory read/write cycles
//  DMA_WAIT_STATES  1    wait clocks inserted on any command while address_enable_n=1 (DMA owns bus)
//  TIMEOUT_CYCLES   256  HOLD clocks before forced completion; 0 disables timeout
// PORTS
//  clock             in   1  system clock; all flops on posedge
//  reset_n           in   1  asynchronous, active-low reset
//  io_read_n         in   1  I/O read strobe from arbiter
//  io_write_n        in   1  I/O write strobe from arbiter
//  memory_read_n     in   1  memory read strobe from arbiter
//  memory_write_n    in   1  memory write strobe from arbiter
//  address_enable_n  in   1  1 = DMA owns bus (from arbiter)
//  dma_wait_n        in   1  DMA wait from arbiter; 0 holds CPU not-ready
//  io_channel_ready  in   1  expansion-bus ready, asynchronous, 0 = extend cycle
//  processor_ready   out  1  READY to CPU = ready_q & dma_wait_n
//  dma_ready         out  1  READY to 8237; ready_q while address_enable_n=1, else 1
//  bus_timeout       out  1  one-clock pulse on forced completion
// BEHAVIOUR
//  Reset: state IDLE, ready_q=1, counters 0, sync flops=1, bus_timeout=0; processor_ready follows dma_wait_n.
//  io_channel_ready passes a 2-flop synchronizer (reset value 1) -> rdy_s; 2-clock latency.
//  cmd_active = ~(io_read_n & io_write_n & memory_read_n & memory_write_n); cmd_start = cmd_active & ~cmd_active_q.
//  Wait count on cmd_start: address_enable_n=1 -> DMA_WAIT_STATES; else any I/O strobe low -> IO_WAIT_STATES
//   (I/O wins if I/O and memory strobes low together); else MEM_WAIT_STATES.
//  FSM (registered, one transition per clock):
//   IDLE: cmd_start & count>0 -> WAIT (load count-1); cmd_start & count=0 & ~rdy_s -> HOLD;
//         cmd_start & count=0 & rdy_s -> DONE; ready_q<=0 on entry to WAIT/HOLD, stays 1 for DONE.
//   WAIT: decrement; at 0 -> HOLD if ~rdy_s else DONE; ready_q stays 0.
//   HOLD: rdy_s=1 -> DONE, ready_q<=1; timeout counter increments each clock; reaching TIMEOUT_CYCLES
//         -> DONE, ready_q<=1, bus_timeout=1 for exactly that clock. Counter cleared on leaving HOLD.
//   DONE: ready_q=1; cmd_active=0 -> IDLE. Strobe held low is one cycle; no re-arm until deasserted.
//  Latency: ready_q falls the clock edge after the strobe falls; N wait states give N+1 clocks ready_q=0 min.
//  cmd_active drop in WAIT/HOLD (aborted cycle) -> IDLE, ready_q<=1, no bus_timeout.
//  address_enable_n change mid-cycle does not reload count; only sampled at cmd_start.
//  Counter widths: $clog2(max wait+1) and $clog2(TIMEOUT_CYCLES+1); min width 1; no wrap (saturating compare).
//  Reset asserted mid-cycle: immediate return to reset values; no bus_timeout pulse.
// STRUCTURE
//  Package bus_ready_pkg: typedef enum logic [1:0] {IDLE, WAIT, HOLD, DONE} ready_state_t.
//  Sub-module ready_synchronizer: 2-flop sync, async active-low reset to 1.
//  Remainder (edge detect, counters, FSM, output gating) inline.
// TESTING
//  Reset low mid-WAIT -> processor_ready=dma_wait_n, dma_ready=1, bus_timeout=0 immediately.
//  io_read_n low 6 clocks, io_channel_ready=1, IO_WAIT_STATES=1 -> processor_ready low 2 clocks, then 1.
//  memory_read_n low, MEM_WAIT_STATES=0, ready=1 -> processor_ready never drops.
//  io_write_n low, io_channel_ready=0 for 10 clocks -> ready low until 2 clocks after it returns to 1.
//  TIMEOUT_CYCLES=8, io_channel_ready stuck 0 -> bus_timeout single pulse, processor_ready=1 same clock.
//  address_enable_n=1, memory_write_n low, DMA_WAIT_STATES=1 -> dma_ready low 2 clocks; dma_wait_n=0 -> processor_ready=0.

Source files
------------

// File: rtl/bus_ready_pkg.sv
// Shared types and helpers for the bus READY / wait-state generator.
package bus_ready_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } ready_state_t;

    // Bits needed to hold 0..max_value, never less than one bit.
    function automatic int unsigned counter_width(input int unsigned max_value);
        int unsigned w;
        w = $clog2(max_value + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_ready_generator_sync.sv
// Two-flop synchronizer for the asynchronous expansion-bus ready line.
// Resets to 1 so an idle bus reads as ready.
module ready_synchronizer (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/bus_ready_generator.sv
// Wait-state and READY generator: inserts programmed wait states on bus
// commands, stretches them on io_channel_ready, and forces completion with a
// one-clock bus_timeout if a stretched cycle never finishes.
module bus_ready_generator
    import bus_ready_pkg::*;
#(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned DMA_WAIT_STATES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic io_read_n,
    input  logic io_write_n,
    input  logic memory_read_n,
    input  logic memory_write_n,
    input  logic address_enable_n,
    input  logic dma_wait_n,
    input  logic io_channel_ready,
    output logic processor_ready,
    output logic dma_ready,
    output logic bus_timeout
);

    localparam int unsigned MAX_WAIT = max3(IO_WAIT_STATES, MEM_WAIT_STATES, DMA_WAIT_STATES);
    localparam int unsigned WW       = counter_width(MAX_WAIT);
    localparam int unsigned TW       = counter_width(TIMEOUT_CYCLES);

    localparam logic [WW-1:0] IO_W   = WW'(IO_WAIT_STATES);
    localparam logic [WW-1:0] MEM_W  = WW'(MEM_WAIT_STATES);
    localparam logic [WW-1:0] DMA_W  = WW'(DMA_WAIT_STATES);
    localparam logic [WW-1:0] ONE_W  = WW'(1);
    localparam logic [TW-1:0] ONE_T  = TW'(1);

    ready_state_t  state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [TW-1:0] hold_cnt_q, hold_cnt_d;
    logic          ready_q, ready_d;
    logic          timeout_q, timeout_d;
    logic          cmd_active_q;

    logic          rdy_s;
    logic          cmd_active;
    logic          cmd_start;
    logic          io_strobe;
    logic [WW-1:0] wait_sel;
    logic          hold_expired;

    ready_synchronizer u_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (io_channel_ready),
        .sync_out (rdy_s)
    );

    assign cmd_active = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
    assign cmd_start  = cmd_active & ~cmd_active_q;
    assign io_strobe  = ~(io_read_n & io_write_n);

    // Wait count chosen at command start: DMA ownership first, then I/O over memory.
    always_comb begin
        wait_sel = MEM_W;
        if (address_enable_n)
            wait_sel = DMA_W;
        else if (io_strobe)
            wait_sel = IO_W;
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign hold_expired = 1'b0;
        end else begin : g_timeout
            // Counter holds completed HOLD clocks; this clock is the last allowed one.
            assign hold_expired = (hold_cnt_q >= TW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

    // State, counters, READY and timeout pulse registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            ready_q      <= 1'b1;
            timeout_q    <= 1'b0;
            cmd_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            ready_q      <= ready_d;
            timeout_q    <= timeout_d;
            cmd_active_q <= cmd_active;
        end
    end

    // Next-state logic; a WAIT->DONE exit keeps READY low one more clock so
    // N wait states always yield N+1 not-ready clocks.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hold_cnt_d = '0;
        ready_d    = ready_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (cmd_start) begin
                    if (wait_sel != '0) begin
                        state_d    = WAIT;
                        wait_cnt_d = wait_sel - ONE_W;
                        ready_d    = 1'b0;
                    end else if (!rdy_s) begin
                        state_d = HOLD;
                        ready_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (!cmd_active) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                    ready_d    = 1'b1;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - ONE_W;
                end else if (rdy_s) begin
                    state_d = DONE;
                end else begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!cmd_active) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else if (rdy_s) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else if (hold_expired) begin
                    state_d   = DONE;
                    ready_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = (hold_cnt_q != '1) ? hold_cnt_q + ONE_T : hold_cnt_q;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                if (!cmd_active)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign processor_ready = ready_q & dma_wait_n;
    assign dma_ready       = address_enable_n ? ready_q : 1'b1;
    assign bus_timeout     = timeout_q;

endmodule

// File: tb/tb_bus_ready_generator.sv
// Self-checking bench: two DUTs (timeout 256 and 8) share one random stimulus
// stream and are compared every clock against a behavioural bus-cycle model.
module tb_bus_ready_generator;

    logic clock = 1'b0;
    logic reset_n;
    logic io_read_n, io_write_n, memory_read_n, memory_write_n;
    logic address_enable_n, dma_wait_n, io_channel_ready;
    logic pr_a, dr_a, to_a;
    logic pr_b, dr_b, to_b;

    always #5 clock = ~clock;

    bus_ready_generator #(
        .IO_WAIT_STATES  (1),
        .MEM_WAIT_STATES (0),
        .DMA_WAIT_STATES (1),
        .TIMEOUT_CYCLES  (256)
    ) dut_a (
        .clock            (clock),
        .reset_n          (reset_n),
        .io_read_n        (io_read_n),
        .io_write_n       (io_write_n),
        .memory_read_n    (memory_read_n),
        .memory_write_n   (memory_write_n),
        .address_enable_n (address_enable_n),
        .dma_wait_n       (dma_wait_n),
        .io_channel_ready (io_channel_ready),
        .processor_ready  (pr_a),
        .dma_ready        (dr_a),
        .bus_timeout      (to_a)
    );

    bus_ready_generator #(
        .IO_WAIT_STATES  (1),
        .MEM_WAIT_STATES (0),
        .DMA_WAIT_STATES (1),
        .TIMEOUT_CYCLES  (8)
    ) dut_b (
        .clock            (clock),
        .reset_n          (reset_n),
        .io_read_n        (io_read_n),
        .io_write_n       (io_write_n),
        .memory_read_n    (memory_read_n),
        .memory_write_n   (memory_write_n),
        .address_enable_n (address_enable_n),
        .dma_wait_n       (dma_wait_n),
        .io_channel_ready (io_channel_ready),
        .processor_ready  (pr_b),
        .dma_ready        (dr_b),
        .bus_timeout      (to_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_bit(input string name, input logic got, input logic want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, want, $time);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    endtask

    // ---------------- behavioural model ----------------
    localparam int IO_W = 1, MEM_W = 0, DMA_W = 1;
    int to_lim [2] = '{256, 8};

    bit m_in_cycle [2];   // command accepted, READY withheld
    bit m_finished [2];   // cycle complete, waiting for strobes to release
    bit m_ready    [2];
    bit m_pulse    [2];
    int m_waits    [2];   // remaining wait clocks; -1 once stretching on ready
    int m_held     [2];   // clocks spent stretching
    bit m_prev_act;
    bit dly [2];          // io_channel_ready as seen 1 and 2 clocks ago

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_in_cycle[i] = 0; m_finished[i] = 0; m_ready[i] = 1;
            m_pulse[i] = 0; m_waits[i] = 0; m_held[i] = 0;
        end
        m_prev_act = 0;
        dly[0] = 1; dly[1] = 1;
    endtask

    task automatic model_step();
        bit act, start, rs, io_low;
        int n;
        act    = !(io_read_n && io_write_n && memory_read_n && memory_write_n);
        start  = act && !m_prev_act;
        rs     = dly[1];
        io_low = !io_read_n || !io_write_n;
        n      = address_enable_n ? DMA_W : (io_low ? IO_W : MEM_W);
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (m_in_cycle[i]) begin
                if (!act) begin
                    m_in_cycle[i] = 0; m_ready[i] = 1; m_held[i] = 0;
                end else if (m_waits[i] > 0) begin
                    m_waits[i]--;
                end else if (m_waits[i] == 0) begin
                    if (rs) begin m_in_cycle[i] = 0; m_finished[i] = 1; end
                    else m_waits[i] = -1;
                end else if (rs) begin
                    m_in_cycle[i] = 0; m_finished[i] = 1; m_ready[i] = 1; m_held[i] = 0;
                end else begin
                    m_held[i]++;
                    if (to_lim[i] != 0 && m_held[i] >= to_lim[i]) begin
                        m_in_cycle[i] = 0; m_finished[i] = 1; m_ready[i] = 1;
                        m_pulse[i] = 1; m_held[i] = 0;
                    end
                end
            end else if (m_finished[i]) begin
                m_ready[i] = 1;
                if (!act) m_finished[i] = 0;
            end else if (start) begin
                if (n > 0) begin
                    m_in_cycle[i] = 1; m_waits[i] = n - 1; m_held[i] = 0; m_ready[i] = 0;
                end else if (!rs) begin
                    m_in_cycle[i] = 1; m_waits[i] = -1; m_held[i] = 0; m_ready[i] = 0;
                end else begin
                    m_finished[i] = 1;
                end
            end
        end
        m_prev_act = act;
        dly[1] = dly[0];
        dly[0] = io_channel_ready;
    endtask

    // Advance the model at each edge and compare both DUTs against it.
    always @(posedge clock) begin
        #1;
        if (!reset_n) model_reset();
        else model_step();
        check_bit("proc_ready_a", pr_a, m_ready[0] & dma_wait_n);
        check_bit("dma_ready_a",  dr_a, address_enable_n ? m_ready[0] : 1'b1);
        check_bit("timeout_a",    to_a, m_pulse[0]);
        check_bit("proc_ready_b", pr_b, m_ready[1] & dma_wait_n);
        check_bit("dma_ready_b",  dr_b, address_enable_n ? m_ready[1] : 1'b1);
        check_bit("timeout_b",    to_b, m_pulse[1]);
    end

    // ---------------- stimulus ----------------
    int   lo_pr_a, lo_dr_a, lo_m_a, lo_md_a, to_a_cnt, to_b_cnt;
    logic to_b_pr;

    task automatic clear_counts();
        lo_pr_a = 0; lo_dr_a = 0; lo_m_a = 0; lo_md_a = 0;
        to_a_cnt = 0; to_b_cnt = 0; to_b_pr = 1'b0;
    endtask

    // One clock: sample after the edge, return at the falling edge to drive.
    task automatic tick();
        @(posedge clock);
        #2;
        if (!pr_a) lo_pr_a++;
        if (!dr_a) lo_dr_a++;
        if (!(m_ready[0] & dma_wait_n)) lo_m_a++;
        if (address_enable_n && !m_ready[0]) lo_md_a++;
        if (to_a) to_a_cnt++;
        if (to_b) begin to_b_cnt++; to_b_pr = pr_b; end
        @(negedge clock);
    endtask

    task automatic strobes_idle();
        io_read_n = 1; io_write_n = 1; memory_read_n = 1; memory_write_n = 1;
    endtask

    initial begin
        logic [3:0] pat;
        int len, gap;

        reset_n = 0; strobes_idle();
        address_enable_n = 0; dma_wait_n = 1; io_channel_ready = 1;
        clear_counts();
        tick(); tick();

        // Reset values, processor_ready tracking dma_wait_n.
        check_bit("reset proc_ready", pr_a, 1'b1);
        check_bit("reset dma_ready",  dr_a, 1'b1);
        check_bit("reset timeout",    to_a, 1'b0);
        dma_wait_n = 0; #1;
        check_bit("reset proc_ready follows dma_wait_n", pr_a, 1'b0);
        dma_wait_n = 1;
        @(negedge clock);
        reset_n = 1;
        tick();

        // I/O read, one wait state, channel ready.
        clear_counts();
        io_read_n = 0;
        repeat (6) tick();
        io_read_n = 1;
        repeat (3) tick();
        check_int("io_read low clocks", lo_pr_a, 2);
        check_int("model io_read low clocks", lo_m_a, 2);

        // Memory read, zero wait states.
        clear_counts();
        memory_read_n = 0;
        repeat (6) tick();
        memory_read_n = 1;
        repeat (3) tick();
        check_int("mem_read low clocks", lo_pr_a, 0);

        // I/O write stretched by io_channel_ready low for 10 clocks.
        io_channel_ready = 0;
        tick(); tick();
        clear_counts();
        io_write_n = 0;
        repeat (8) tick();
        io_channel_ready = 1;
        repeat (4) tick();
        io_write_n = 1;
        repeat (3) tick();
        check_int("io_write stretched low clocks", lo_pr_a, 10);
        check_int("model io_write stretched low clocks", lo_m_a, 10);
        check_int("no timeout at 256 during stretch", to_a_cnt, 0);

        // Timeout on the short-timeout instance.
        io_channel_ready = 0;
        tick(); tick();
        clear_counts();
        io_read_n = 0;
        repeat (14) tick();
        check_int("timeout pulse count b", to_b_cnt, 1);
        check_bit("proc_ready with timeout b", to_b_pr, 1'b1);
        check_int("timeout pulse count a", to_a_cnt, 0);
        io_read_n = 1; io_channel_ready = 1;
        repeat (3) tick();

        // DMA-owned memory write.
        clear_counts();
        address_enable_n = 1; memory_write_n = 0;
        repeat (6) tick();
        check_int("dma_ready low clocks", lo_dr_a, 2);
        check_int("model dma_ready low clocks", lo_md_a, 2);
        dma_wait_n = 0; #1;
        check_bit("dma_wait_n gates proc_ready", pr_a, 1'b0);
        dma_wait_n = 1;
        memory_write_n = 1; address_enable_n = 0;
        repeat (3) tick();

        // Reset in the middle of a wait state.
        address_enable_n = 1; io_read_n = 0;
        tick();
        check_bit("mid-wait proc_ready", pr_a, 1'b0);
        check_bit("mid-wait dma_ready",  dr_a, 1'b0);
        reset_n = 0; #1;
        check_bit("reset mid-wait proc_ready", pr_a, 1'b1);
        check_bit("reset mid-wait dma_ready",  dr_a, 1'b1);
        check_bit("reset mid-wait timeout",    to_a, 1'b0);
        strobes_idle(); address_enable_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();

        // Randomised traffic.
        for (int t = 0; t < 250; t++) begin
            pat = 4'($urandom_range(1, 15));
            {io_read_n, io_write_n, memory_read_n, memory_write_n} = ~pat;
            address_enable_n = ($urandom_range(0, 3) == 0);
            dma_wait_n       = ($urandom_range(0, 4) != 0);
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 5) == 0)  io_channel_ready = ~io_channel_ready;
                if ($urandom_range(0, 7) == 0)  dma_wait_n = ~dma_wait_n;
                if ($urandom_range(0, 11) == 0) address_enable_n = ~address_enable_n;
                tick();
            end
            strobes_idle();
            gap = $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) begin
                if ($urandom_range(0, 5) == 0) io_channel_ready = ~io_channel_ready;
                tick();
            end
            if ($urandom_range(0, 40) == 0) begin
                reset_n = 0; #1;
                check_bit("random reset proc_ready", pr_a, dma_wait_n);
                check_bit("random reset dma_ready",  dr_a, 1'b1);
                check_bit("random reset timeout",    to_b, 1'b0);
                tick();
                reset_n = 1;
            end
        end

        strobes_idle();
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
